execute: RTL and testbench

Execute stage of the in-order RV32IM core: sits between decode and writeback. It takes decoded operands (register A/B, extended immediate, destination register, write enable) and computes the result. Base-ISA ALU operations complete in one cycle. RV32M multiply/divide runs on a shared iterative unit that stalls upstream stages. A registered EX/WB boundary drives writeback's `alu_out_i` and the register-file write controls.

---
 rtl/execute_if.sv | 29 ++
 rtl/execute.sv | 229 ++++++++++++++++++++++
 tb/tb_execute.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_if.sv
// Handshake and data bundle between decode and the execute stage.
// Decode drives the master side; the execute stage is the slave.
interface execute_if;
    logic        valid_i;
    logic [4:0]  alu_op_i;
    logic        src_b_sel_i;
    logic [31:0] reg_a_i;
    logic [31:0] reg_b_i;
    logic [31:0] imm_ext_i;
    logic [4:0]  rd_addr_i;
    logic        regfile_wen_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] alu_out_o;
    logic [4:0]  rd_addr_o;
    logic        regfile_wen_o;

    modport master (
        output valid_i, alu_op_i, src_b_sel_i, reg_a_i, reg_b_i, imm_ext_i,
               rd_addr_i, regfile_wen_i,
        input  stall_o, valid_o, alu_out_o, rd_addr_o, regfile_wen_o
    );

    modport slave (
        input  valid_i, alu_op_i, src_b_sel_i, reg_a_i, reg_b_i, imm_ext_i,
               rd_addr_i, regfile_wen_i,
        output stall_o, valid_o, alu_out_o, rd_addr_o, regfile_wen_o
    );
endinterface

// File: rtl/execute.sv
// RV32IM execute stage: single-cycle ALU, iterative radix-2 multiply/divide
// unit that stalls upstream, and the registered EX/WB boundary.
module execute #(
    parameter bit MD_EN = 1'b1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    execute_if.slave ex
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    logic [1:0]  state_reg, state_next;
    logic [4:0]  count_reg;
    logic [4:0]  op_reg;
    logic [4:0]  rd_reg;
    logic        wen_reg;
    logic        special_reg;
    logic        sign_q_reg;
    logic        sign_r_reg;
    logic [31:0] x_reg;
    logic [63:0] p_reg;

    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_result;

    assign op_b  = ex.src_b_sel_i ? ex.imm_ext_i : ex.reg_b_i;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_result = 32'd0;
        case (ex.alu_op_i)
            OP_ADD:  alu_result = ex.reg_a_i + op_b;
            OP_SUB:  alu_result = ex.reg_a_i - op_b;
            OP_SLL:  alu_result = ex.reg_a_i << shamt;
            OP_SLT:  alu_result = {31'd0, $signed(ex.reg_a_i) < $signed(op_b)};
            OP_SLTU: alu_result = {31'd0, ex.reg_a_i < op_b};
            OP_XOR:  alu_result = ex.reg_a_i ^ op_b;
            OP_SRL:  alu_result = ex.reg_a_i >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(ex.reg_a_i) >>> shamt);
            OP_OR:   alu_result = ex.reg_a_i | op_b;
            OP_AND:  alu_result = ex.reg_a_i & op_b;
            default: alu_result = 32'd0;
        endcase
    end

    // Without the M unit, M opcodes fall through the ALU as reserved (result 0).
    logic op_in_m_range;
    logic is_m_op;
    assign op_in_m_range = (ex.alu_op_i >= OP_MUL) && (ex.alu_op_i <= OP_REMU);

    generate
        if (MD_EN) begin : g_md
            assign is_m_op = op_in_m_range;
        end else begin : g_no_md
            assign is_m_op = 1'b0;
        end
    endgenerate

    logic        start_m;
    logic        op_is_div;
    logic        a_signed, b_signed;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic        div_by_zero, div_ovf, is_special;
    logic [31:0] special_val;

    assign start_m   = (state_reg == S_IDLE) && ex.valid_i && is_m_op;
    assign op_is_div = (ex.alu_op_i >= OP_DIV);
    assign a_signed  = (ex.alu_op_i == OP_MUL) || (ex.alu_op_i == OP_MULH) ||
                       (ex.alu_op_i == OP_MULHSU) || (ex.alu_op_i == OP_DIV) ||
                       (ex.alu_op_i == OP_REM);
    assign b_signed  = (ex.alu_op_i == OP_MUL) || (ex.alu_op_i == OP_MULH) ||
                       (ex.alu_op_i == OP_DIV) || (ex.alu_op_i == OP_REM);
    assign a_neg     = a_signed && ex.reg_a_i[31];
    assign b_neg     = b_signed && op_b[31];
    assign mag_a     = a_neg ? (32'd0 - ex.reg_a_i) : ex.reg_a_i;
    assign mag_b     = b_neg ? (32'd0 - op_b) : op_b;

    assign div_by_zero = op_is_div && (op_b == 32'd0);
    assign div_ovf     = ((ex.alu_op_i == OP_DIV) || (ex.alu_op_i == OP_REM)) &&
                         (ex.reg_a_i == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign is_special  = div_by_zero || div_ovf;

    always_comb begin
        special_val = 32'd0;
        if (div_by_zero) begin
            special_val = ((ex.alu_op_i == OP_DIV) || (ex.alu_op_i == OP_DIVU)) ?
                          32'hFFFF_FFFF : ex.reg_a_i;
        end else if (div_ovf) begin
            special_val = (ex.alu_op_i == OP_DIV) ? 32'h8000_0000 : 32'd0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_m) state_next = is_special ? S_DONE : S_BUSY;
            S_BUSY:  if (count_reg == 5'd31) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign ex.stall_o = !rst_i && (start_m || (state_reg == S_BUSY));

    // One radix-2 step. Multiply: p = {acc, multiplier}, x = multiplicand.
    // Divide: p = {partial remainder, dividend/quotient}, x = divisor.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic        op_reg_is_mul;

    assign mul_sum   = {1'b0, p_reg[63:32]} + (p_reg[0] ? {1'b0, x_reg} : 33'd0);
    assign mul_next  = {mul_sum, p_reg[31:1]};
    assign div_shift = {p_reg[63:32], p_reg[31]};
    assign div_ge    = div_shift >= {1'b0, x_reg};
    assign div_diff  = div_shift[31:0] - x_reg;
    assign div_next  = {(div_ge ? div_diff : div_shift[31:0]), p_reg[30:0], div_ge};
    assign op_reg_is_mul = (op_reg <= OP_MULHU);

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] m_result;

    assign prod_fix = sign_q_reg ? (64'd0 - p_reg) : p_reg;
    assign quo_fix  = sign_q_reg ? (32'd0 - p_reg[31:0]) : p_reg[31:0];
    assign rem_fix  = sign_r_reg ? (32'd0 - p_reg[63:32]) : p_reg[63:32];

    always_comb begin
        m_result = 32'd0;
        if (special_reg) begin
            m_result = x_reg;
        end else begin
            case (op_reg)
                OP_MUL:                       m_result = prod_fix[31:0];
                OP_MULH, OP_MULHSU, OP_MULHU: m_result = prod_fix[63:32];
                OP_DIV, OP_DIVU:              m_result = quo_fix;
                default:                      m_result = rem_fix;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= S_IDLE;
            count_reg   <= 5'd0;
            op_reg      <= 5'd0;
            rd_reg      <= 5'd0;
            wen_reg     <= 1'b0;
            special_reg <= 1'b0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            x_reg       <= 32'd0;
            p_reg       <= 64'd0;
        end else begin
            state_reg <= state_next;
            if (start_m) begin
                op_reg      <= ex.alu_op_i;
                rd_reg      <= ex.rd_addr_i;
                wen_reg     <= ex.regfile_wen_i;
                special_reg <= is_special;
                count_reg   <= 5'd0;
                sign_q_reg  <= a_neg ^ b_neg;
                sign_r_reg  <= a_neg;
                if (is_special) begin
                    x_reg <= special_val;
                    p_reg <= 64'd0;
                end else if (op_is_div) begin
                    x_reg <= mag_b;
                    p_reg <= {32'd0, mag_a};
                end else begin
                    x_reg <= mag_a;
                    p_reg <= {32'd0, mag_b};
                end
            end else if (state_reg == S_BUSY) begin
                p_reg     <= op_reg_is_mul ? mul_next : div_next;
                count_reg <= count_reg + 5'd1;
            end
        end
    end

    // EX/WB boundary: M result in DONE, ALU result when idle, bubble otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex.valid_o       <= 1'b0;
            ex.alu_out_o     <= 32'd0;
            ex.rd_addr_o     <= 5'd0;
            ex.regfile_wen_o <= 1'b0;
        end else if (state_reg == S_DONE) begin
            ex.valid_o       <= 1'b1;
            ex.alu_out_o     <= m_result;
            ex.rd_addr_o     <= rd_reg;
            ex.regfile_wen_o <= wen_reg;
        end else if ((state_reg == S_IDLE) && ex.valid_i && !is_m_op) begin
            ex.valid_o       <= 1'b1;
            ex.alu_out_o     <= alu_result;
            ex.rd_addr_o     <= ex.rd_addr_i;
            ex.regfile_wen_o <= ex.regfile_wen_i;
        end else begin
            ex.valid_o       <= 1'b0;
            ex.regfile_wen_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: cycle-level reference model
// plus directed instructions with hand-computed results.
module tb_execute;
    logic clk_i = 1'b0;
    logic rst_i;

    execute_if bus ();

    execute #(.MD_EN(1'b1)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ex    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_m(input logic [4:0] op);
        return (op >= 5'd10) && (op <= 5'd17);
    endfunction

    function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op >= 5'd14 && op <= 5'd17 && b == 32'd0) ||
               ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Result straight from the ISA definition of each operation.
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int                 ia, ib;
        logic signed [31:0] sa32;
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic [4:0]         sh;
        ia   = a;
        ib   = b;
        sa32 = a;
        sh   = b[4:0];
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << sh;
            5'd3:  return (ia < ib) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> sh;
            5'd7:  return sa32 >>> sh;
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: begin sp = longint'(ia) * longint'(ib); return sp[31:0]; end
            5'd11: begin sp = longint'(ia) * longint'(ib); return sp[63:32]; end
            5'd12: begin sp = longint'(ia) * longint'({32'd0, b}); return sp[63:32]; end
            5'd13: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            5'd14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            5'd17: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] cur_b();
        return bus.src_b_sel_i ? bus.imm_ext_i : bus.reg_b_i;
    endfunction

    // Model: an M op holds the slot for 33 (or 1 special) stall cycles; the
    // cycle stall drops, the slot advances and its result lands next edge.
    int          hold_cnt  = 0;
    bit          released  = 1'b0;
    bit          exp_stall = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_wen   = 1'b0;
    logic [31:0] exp_out   = 32'd0;
    logic [4:0]  exp_rd    = 5'd0;

    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                hold_cnt = 0; released = 1'b0; exp_stall = 1'b0;
                exp_valid = 1'b0; exp_wen = 1'b0; exp_out = 32'd0; exp_rd = 5'd0;
            end else if (exp_stall) begin
                hold_cnt--;
                if (hold_cnt == 0) released = 1'b1;
                exp_valid = 1'b0;
                exp_wen   = 1'b0;
            end else begin
                released = 1'b0;
                if (bus.valid_i) begin
                    exp_valid = 1'b1;
                    exp_out   = ref_result(bus.alu_op_i, bus.reg_a_i, cur_b());
                    exp_rd    = bus.rd_addr_i;
                    exp_wen   = bus.regfile_wen_i;
                end else begin
                    exp_valid = 1'b0;
                    exp_wen   = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                exp_stall = 1'b0;
            end else begin
                if (hold_cnt == 0 && !released && bus.valid_i && is_m(bus.alu_op_i))
                    hold_cnt = is_special(bus.alu_op_i, bus.reg_a_i, cur_b()) ? 1 : 33;
                exp_stall = (hold_cnt > 0);
            end
            chk("cyc stall",    {31'd0, bus.stall_o},       {31'd0, exp_stall});
            chk("cyc valid",    {31'd0, bus.valid_o},       {31'd0, exp_valid});
            chk("cyc wen",      {31'd0, bus.regfile_wen_o}, {31'd0, exp_wen});
            chk("cyc alu_out",  bus.alu_out_o,              exp_out);
            chk("cyc rd",       {27'd0, bus.rd_addr_o},     {27'd0, exp_rd});
        end
    end

    // Called just after a rising edge; returns just after the result edge.
    task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit sel, input logic [4:0] rd,
                         input bit wen, input logic [31:0] lit, input int exp_st);
        int n;
        bus.valid_i       = 1'b1;
        bus.alu_op_i      = op;
        bus.reg_a_i       = a;
        bus.src_b_sel_i   = sel;
        bus.reg_b_i       = sel ? $urandom : b;
        bus.imm_ext_i     = sel ? b : $urandom;
        bus.rd_addr_i     = rd;
        bus.regfile_wen_i = wen;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (!bus.stall_o) break;
            n++;
        end
        @(posedge clk_i);
        #1;
        chk({name, " result"}, bus.alu_out_o, lit);
        chk({name, " stall cycles"}, 32'(n), 32'(exp_st));
        chk({name, " valid"}, {31'd0, bus.valid_o}, 32'd1);
        chk({name, " rd"}, {27'd0, bus.rd_addr_o}, {27'd0, rd});
        chk({name, " wen"}, {31'd0, bus.regfile_wen_o}, {31'd0, wen});
        $display("[TB] %s op=%0d a=%h b=%h -> %h stall=%0d", name, op, a, b, bus.alu_out_o, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        bus.valid_i = 1'b0; bus.alu_op_i = 5'd0; bus.src_b_sel_i = 1'b0;
        bus.reg_a_i = 32'd0; bus.reg_b_i = 32'd0; bus.imm_ext_i = 32'd0;
        bus.rd_addr_i = 5'd0; bus.regfile_wen_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset valid", {31'd0, bus.valid_o}, 32'd0);
        chk("reset alu_out", bus.alu_out_o, 32'd0);
        chk("reset stall", {31'd0, bus.stall_o}, 32'd0);
        rst_i = 1'b0;

        issue("ADD imm",   5'd0,  32'd5,         32'hFFFF_FFFD, 1'b1, 5'd7,  1'b1, 32'd2,         0);
        issue("SRA",       5'd7,  32'h8000_0000, 32'h24,        1'b0, 5'd1,  1'b1, 32'hF800_0000, 0);
        issue("SLTU",      5'd4,  32'd1,         32'hFFFF_FFFF, 1'b0, 5'd2,  1'b1, 32'd1,         0);
        issue("SLT",       5'd3,  32'd1,         32'hFFFF_FFFF, 1'b0, 5'd3,  1'b1, 32'd0,         0);
        issue("SUB",       5'd1,  32'd3,         32'd5,         1'b0, 5'd4,  1'b1, 32'hFFFF_FFFE, 0);
        issue("SLL",       5'd2,  32'd1,         32'h3F,        1'b1, 5'd5,  1'b1, 32'h8000_0000, 0);
        issue("SRL",       5'd6,  32'h8000_0000, 32'd4,         1'b0, 5'd6,  1'b1, 32'h0800_0000, 0);
        issue("XOR",       5'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 5'd8,  1'b1, 32'hFF00_FF00, 0);
        issue("OR",        5'd8,  32'h00FF_0000, 32'h0000_00FF, 1'b1, 5'd9,  1'b1, 32'h00FF_00FF, 0);
        issue("AND nowen", 5'd9,  32'hFFFF_0000, 32'h1234_5678, 1'b0, 5'd10, 1'b0, 32'h1234_0000, 0);
        issue("RSVD",      5'd20, 32'h1234_5678, 32'd9,         1'b0, 5'd11, 1'b1, 32'd0,         0);

        bus.valid_i = 1'b0;
        @(posedge clk_i); #1;

        issue("MULH",      5'd11, 32'hFFFF_FFFF, 32'd2,         1'b0, 5'd12, 1'b1, 32'hFFFF_FFFF, 33);
        issue("MUL",       5'd10, 32'h0001_0000, 32'h0001_0000, 1'b0, 5'd13, 1'b1, 32'd0,         33);
        issue("MUL neg",   5'd10, 32'hFFFF_FFFD, 32'd5,         1'b1, 5'd14, 1'b1, 32'hFFFF_FFF1, 33);
        issue("MULHSU",    5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd15, 1'b1, 32'hFFFF_FFFF, 33);
        issue("MULHU",     5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd16, 1'b1, 32'hFFFF_FFFE, 33);
        issue("DIV by0",   5'd14, 32'd7,         32'd0,         1'b0, 5'd17, 1'b1, 32'hFFFF_FFFF, 1);
        issue("REM by0",   5'd16, 32'd7,         32'd0,         1'b0, 5'd18, 1'b1, 32'd7,         1);
        issue("DIV ovf",   5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd19, 1'b1, 32'h8000_0000, 1);
        issue("REM ovf",   5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd20, 1'b1, 32'd0,         1);
        issue("DIV neg",   5'd14, 32'hFFFF_FFF9, 32'd2,         1'b0, 5'd21, 1'b1, 32'hFFFF_FFFD, 33);
        issue("REM neg",   5'd16, 32'hFFFF_FFF9, 32'd2,         1'b1, 5'd22, 1'b1, 32'hFFFF_FFFF, 33);
        issue("DIVU",      5'd15, 32'hFFFF_FFFF, 32'd2,         1'b0, 5'd23, 1'b1, 32'h7FFF_FFFF, 33);
        issue("REMU",      5'd17, 32'd100,       32'd7,         1'b0, 5'd24, 1'b1, 32'd2,         33);
        issue("ADD after", 5'd0,  32'd10,        32'd20,        1'b0, 5'd25, 1'b1, 32'd30,        0);

        // Abort a DIVU mid-iteration with an asynchronous reset pulse.
        bus.valid_i = 1'b1; bus.alu_op_i = 5'd15; bus.src_b_sel_i = 1'b0;
        bus.reg_a_i = 32'hFFFF_FFFF; bus.reg_b_i = 32'd3;
        bus.rd_addr_i = 5'd26; bus.regfile_wen_i = 1'b1;
        repeat (11) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        bus.alu_op_i = 5'd0; bus.reg_a_i = 32'd3; bus.reg_b_i = 32'd4; bus.rd_addr_i = 5'd9;
        #1;
        chk("rst valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst alu_out", bus.alu_out_o, 32'd0);
        chk("rst rd", {27'd0, bus.rd_addr_o}, 32'd0);
        chk("rst wen", {31'd0, bus.regfile_wen_o}, 32'd0);
        chk("rst stall", {31'd0, bus.stall_o}, 32'd0);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("post-rst ADD result", bus.alu_out_o, 32'd7);
        chk("post-rst ADD valid", {31'd0, bus.valid_o}, 32'd1);
        chk("post-rst ADD rd", {27'd0, bus.rd_addr_o}, 32'd9);
        $display("[TB] reset abort of DIVU, then ADD 3+4 -> %h", bus.alu_out_o);

        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
